// File: rtl/fetch_seq_if.sv
// Bundle of CODE-fetch handshake and sequencer status signals.
// Handshake: code_req is the request (valid) from the sequencer and code_rdy
// is the memory's ready; a byte transfers only in a cycle where both are 1.
interface fetch_seq_if;
    logic [7:0] code_data;
    logic       code_rdy;
    logic [1:0] len_lut;
    logic [1:0] cyc_lut;
    logic       hold;
    logic       code_req;
    logic       pc_inc;
    logic [2:0] state;
    logic [1:0] cycles;
    logic [7:0] IR;
    logic [7:0] direct;
    logic [7:0] operand2;
    logic       ins_start;
    logic       ins_end;

    // Sequencer side.
    modport slave (
        input  code_data, code_rdy, len_lut, cyc_lut, hold,
        output code_req, pc_inc, state, cycles, IR, direct, operand2,
               ins_start, ins_end
    );

    // Memory/decoder/environment side.
    modport master (
        output code_data, code_rdy, len_lut, cyc_lut, hold,
        input  code_req, pc_inc, state, cycles, IR, direct, operand2,
               ins_start, ins_end
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: steps phases S1..S6 per machine cycle, fetches
// the opcode and up to two operand bytes in fixed slots, and counts down the
// machine cycles of each instruction. The phase register is exposed on state.
module fetch_seq (
    input  logic       clk,
    input  logic       rst,
    fetch_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_S6   = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_cycles;     // machine cycles left after the current one
    logic [1:0] r_mc;         // index of the current machine cycle
    logic [1:0] r_len;        // byte length of the current instruction (1..3)
    logic [7:0] r_ir;
    logic [7:0] r_direct;
    logic [7:0] r_operand2;
    logic       r_pc_inc;
    logic       r_ins_start;

    logic       w_slot_op;
    logic       w_slot_b2;
    logic       w_slot_b3;
    logic       w_slot;
    logic       w_req;
    logic       w_stall;
    logic       w_acc_op;
    logic       w_acc_b2;
    logic       w_acc_b3;
    logic       w_ins_end;
    logic [1:0] w_len_dec;
    logic [1:0] w_cyc_init;

    // Slot decode, stall/handshake, opcode decode and next phase.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_op   = 1'b0;
        w_slot_b2   = 1'b0;
        w_slot_b3   = 1'b0;
        w_slot      = 1'b0;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_acc_op    = 1'b0;
        w_acc_b2    = 1'b0;
        w_acc_b3    = 1'b0;
        w_ins_end   = 1'b0;
        w_len_dec   = 2'd1;
        w_cyc_init  = 2'd0;

        // Opcode in C1 S1, second byte in C1 S4, third byte in C2 S1.
        w_slot_op = (r_state == ST_S1) && (r_mc == 2'd0);
        w_slot_b2 = (r_state == ST_S4) && (r_mc == 2'd0) && (r_len >= 2'd2);
        w_slot_b3 = (r_state == ST_S1) && (r_mc == 2'd1) && (r_len == 2'd3);
        w_slot    = w_slot_op || w_slot_b2 || w_slot_b3;

        w_req    = w_slot && !bus.hold && !rst;
        w_stall  = bus.hold || (w_slot && !bus.code_rdy);
        w_acc_op = w_slot_op && w_req && bus.code_rdy;
        w_acc_b2 = w_slot_b2 && w_req && bus.code_rdy;
        w_acc_b3 = w_slot_b3 && w_req && bus.code_rdy;

        w_ins_end = (r_state == ST_S6) && (r_cycles == 2'd0) && !bus.hold && !rst;

        // Length code 00 behaves as a single-byte opcode.
        w_len_dec = (bus.len_lut == 2'b00) ? 2'd1 : bus.len_lut;

        case (bus.cyc_lut)
            2'b00:   w_cyc_init = 2'd0;
            2'b01:   w_cyc_init = 2'd1;
            default: w_cyc_init = 2'd3;
        endcase
        // A three-byte opcode needs C2 S1 for its last byte, so it spans
        // at least two machine cycles.
        if ((w_len_dec == 2'd3) && (bus.cyc_lut == 2'b00)) begin
            w_cyc_init = 2'd1;
        end

        case (r_state)
            ST_IDLE: w_state_nxt = ST_S1;
            ST_S1:   if (!w_stall) w_state_nxt = ST_S2;
            ST_S2:   if (!w_stall) w_state_nxt = ST_S3;
            ST_S3:   if (!w_stall) w_state_nxt = ST_S4;
            ST_S4:   if (!w_stall) w_state_nxt = ST_S5;
            ST_S5:   if (!w_stall) w_state_nxt = ST_S6;
            ST_S6:   if (!w_stall) w_state_nxt = ST_S1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction bytes, cycle countdown and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles    <= 2'd0;
            r_mc        <= 2'd0;
            r_len       <= 2'd1;
            r_ir        <= 8'h00;
            r_direct    <= 8'h00;
            r_operand2  <= 8'h00;
            r_pc_inc    <= 1'b0;
            r_ins_start <= 1'b0;
        end else begin
            r_pc_inc    <= w_acc_op || w_acc_b2 || w_acc_b3;
            r_ins_start <= w_acc_op;
            if (w_acc_op) begin
                r_ir     <= bus.code_data;
                r_len    <= w_len_dec;
                r_cycles <= w_cyc_init;
                r_mc     <= 2'd0;
            end
            if (w_acc_b2) begin
                r_direct <= bus.code_data;
            end
            if (w_acc_b3) begin
                r_operand2 <= bus.code_data;
            end
            // Leaving S6: either step to the next machine cycle or restart
            // at the opcode slot of the next instruction.
            if ((r_state == ST_S6) && !w_stall) begin
                if (r_cycles != 2'd0) begin
                    r_cycles <= r_cycles - 2'd1;
                    r_mc     <= r_mc + 2'd1;
                end else begin
                    r_mc <= 2'd0;
                end
            end
        end
    end

    assign bus.code_req  = w_req;
    assign bus.pc_inc    = r_pc_inc;
    assign bus.state     = r_state;
    assign bus.cycles    = r_cycles;
    assign bus.IR        = r_ir;
    assign bus.direct    = r_direct;
    assign bus.operand2  = r_operand2;
    assign bus.ins_start = r_ins_start;
    assign bus.ins_end   = w_ins_end;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with an instruction-level reference model that
// tracks each instruction as a linear phase index 0..6N-1.
module tb_fetch_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_seq_if bus();

    fetch_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Byte stream presented by the CODE memory, with decoder outputs.
    logic [7:0] s_byte [0:23];
    logic [1:0] s_len  [0:23];
    logic [1:0] s_cyc  [0:23];
    int         ptr = 0;
    bit         acc_seen = 0;
    bit         started = 0;

    // Reference model state (describes the DUT registers after each edge).
    bit         m_idle = 1;
    int         m_ph = 0;
    int         m_n = 1;
    int         m_len = 1;
    logic [7:0] m_ir = 8'h00;
    logic [7:0] m_dir = 8'h00;
    logic [7:0] m_op2 = 8'h00;
    bit         m_pc = 0;
    bit         m_st = 0;

    // Observed pulse statistics.
    int pc_cnt = 0;
    int end_cnt = 0;
    int cyc_no = 0;
    int t_start = 0;
    int t_len = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic put(input int i, input logic [7:0] b, input logic [1:0] l,
                       input logic [1:0] c);
        s_byte[i] = b;
        s_len[i]  = l;
        s_cyc[i]  = c;
    endtask

    task automatic drive_bytes();
        int k;
        k = (ptr > 23) ? 23 : ptr;
        bus.code_data = s_byte[k];
        bus.len_lut   = s_len[k];
        bus.cyc_lut   = s_cyc[k];
    endtask

    // One clock: advance the memory pointer on an accepted byte.
    task automatic step();
        @(posedge clk);
        #1;
        if (acc_seen) ptr++;
        drive_bytes();
    endtask

    task automatic wait_ph(input int p, input int ph);
        int k;
        k = 0;
        while (!(ptr == p && !m_idle && m_ph == ph) && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) chk("timeout_wait", 0, 1);
    endtask

    // Compare every output against the model, then advance the model.
    always @(negedge clk) begin : compare
        int  e_state, e_cycles;
        bit  e_slot, e_req, e_acc, e_stall, e_end;
        e_state  = m_idle ? 0 : (m_ph % 6) + 1;
        e_cycles = (m_idle || m_ph == 0) ? 0 : m_n - 1 - m_ph / 6;
        e_slot   = !m_idle && (m_ph == 0 || (m_ph == 3 && m_len >= 2) ||
                               (m_ph == 6 && m_len == 3));
        e_req    = e_slot && !bus.hold && !rst;
        e_acc    = e_req && bus.code_rdy;
        e_stall  = bus.hold || (e_slot && !bus.code_rdy);
        e_end    = !m_idle && m_ph == m_n * 6 - 1 && !bus.hold && !rst;

        if (started) begin
            chk("state",     int'(bus.state),     e_state);
            chk("cycles",    int'(bus.cycles),    e_cycles);
            chk("IR",        int'(bus.IR),        int'(m_ir));
            chk("direct",    int'(bus.direct),    int'(m_dir));
            chk("operand2",  int'(bus.operand2),  int'(m_op2));
            chk("code_req",  int'(bus.code_req),  int'(e_req));
            chk("pc_inc",    int'(bus.pc_inc),    int'(m_pc));
            chk("ins_start", int'(bus.ins_start), int'(m_st));
            chk("ins_end",   int'(bus.ins_end),   int'(e_end));
        end

        if (bus.pc_inc === 1'b1) pc_cnt++;
        if (bus.ins_start === 1'b1) t_start = cyc_no;
        if (bus.ins_end === 1'b1) begin
            end_cnt++;
            t_len = cyc_no - t_start;
        end
        cyc_no++;
        acc_seen = e_acc;

        if (rst) begin
            m_idle = 1; m_ph = 0; m_n = 1; m_len = 1;
            m_ir = 8'h00; m_dir = 8'h00; m_op2 = 8'h00;
            m_pc = 0; m_st = 0;
        end else begin
            m_pc = e_acc;
            m_st = e_acc && m_ph == 0;
            if (m_idle) begin
                m_idle = 0;
                m_ph   = 0;
            end else if (!e_stall) begin
                if (e_acc && m_ph == 0) begin
                    m_ir  = bus.code_data;
                    m_len = (bus.len_lut == 2'b00) ? 1 : int'(bus.len_lut);
                    m_n   = (bus.cyc_lut == 2'b00) ? 1 :
                            (bus.cyc_lut == 2'b01) ? 2 : 4;
                    if (m_len == 3 && m_n == 1) m_n = 2;
                end
                if (e_acc && m_ph == 3) m_dir = bus.code_data;
                if (e_acc && m_ph == 6) m_op2 = bus.code_data;
                m_ph = (m_ph + 1 == m_n * 6) ? 0 : m_ph + 1;
            end
        end
    end

    initial begin
        int pc0;
        for (int i = 0; i < 24; i++) put(i, 8'h00, 2'b01, 2'b00);
        put(0,  8'h04, 2'b01, 2'b00);
        put(1,  8'hE5, 2'b10, 2'b00);
        put(2,  8'h30, 2'b01, 2'b00);
        put(3,  8'h02, 2'b11, 2'b00);
        put(4,  8'h12, 2'b01, 2'b00);
        put(5,  8'h34, 2'b01, 2'b00);
        put(6,  8'h75, 2'b10, 2'b10);
        put(7,  8'h55, 2'b01, 2'b00);
        put(8,  8'h85, 2'b11, 2'b01);
        put(9,  8'hAA, 2'b01, 2'b00);
        put(10, 8'hBB, 2'b01, 2'b00);
        put(11, 8'h90, 2'b11, 2'b10);
        put(12, 8'h01, 2'b01, 2'b00);
        put(13, 8'h02, 2'b01, 2'b00);
        put(14, 8'hA5, 2'b00, 2'b11);

        rst = 1'b1;
        bus.hold = 1'b0;
        bus.code_rdy = 1'b1;
        drive_bytes();
        step();
        step();
        started = 1;

        // Reset values, with hold also raised to show reset dominates.
        bus.hold = 1'b1;
        step();
        #1;
        chk("rst_state",    int'(bus.state), 0);
        chk("rst_IR",       int'(bus.IR), 0);
        chk("rst_code_req", int'(bus.code_req), 0);
        bus.hold = 1'b0;
        rst = 1'b0;
        step();
        chk("first_state", int'(bus.state), 1);

        // Single-byte, single-cycle opcode.
        wait_ph(1, 1);
        chk("op04_IR",    int'(bus.IR), 8'h04);
        chk("op04_state", int'(bus.state), 2);
        chk("op04_start", int'(bus.ins_start), 1);
        wait_ph(1, 0);
        chk("op04_pc_cnt",  pc_cnt, 1);
        chk("op04_end_cnt", end_cnt, 1);
        chk("op04_len",     t_len, 4);

        // Two-byte opcode.
        wait_ph(3, 0);
        chk("opE5_direct",  int'(bus.direct), 8'h30);
        chk("opE5_pc_cnt",  pc_cnt, 3);
        chk("opE5_end_cnt", end_cnt, 2);

        // Three-byte opcode with cycle count forced to two.
        wait_ph(4, 1);
        chk("op02_cycles", int'(bus.cycles), 1);
        wait_ph(6, 0);
        chk("op02_direct",   int'(bus.direct), 8'h12);
        chk("op02_operand2", int'(bus.operand2), 8'h34);
        chk("op02_pc_cnt",   pc_cnt, 6);
        chk("op02_end_cnt",  end_cnt, 3);
        chk("op02_len",      t_len, 10);

        // Four machine cycles: countdown 3,2,1,0.
        wait_ph(7, 1);
        chk("op75_cyc_c1", int'(bus.cycles), 3);
        wait_ph(8, 7);
        chk("op75_cyc_c2", int'(bus.cycles), 2);
        wait_ph(8, 13);
        chk("op75_cyc_c3", int'(bus.cycles), 1);
        wait_ph(8, 19);
        chk("op75_cyc_c4", int'(bus.cycles), 0);
        wait_ph(8, 0);
        chk("op75_end_cnt",  end_cnt, 4);
        chk("op75_len",      t_len, 22);
        chk("op75_direct",   int'(bus.direct), 8'h55);
        chk("op75_operand2", int'(bus.operand2), 8'h34);
        chk("op75_pc_cnt",   pc_cnt, 8);

        // Memory not ready, then external hold, in the S4 slot.
        wait_ph(9, 3);
        bus.code_rdy = 1'b0;
        pc0 = pc_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rdy0_state", int'(bus.state), 4);
            chk("rdy0_req",   int'(bus.code_req), 1);
            step();
        end
        bus.code_rdy = 1'b1;
        bus.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_state", int'(bus.state), 4);
            chk("hold_req",   int'(bus.code_req), 0);
            step();
        end
        bus.hold = 1'b0;
        #1;
        chk("stall_pc_cnt", pc_cnt, pc0);
        chk("resume_req",   int'(bus.code_req), 1);
        step();
        chk("resume_state",  int'(bus.state), 5);
        chk("resume_direct", int'(bus.direct), 8'hAA);
        chk("resume_pc_inc", int'(bus.pc_inc), 1);
        wait_ph(11, 0);
        chk("op85_operand2", int'(bus.operand2), 8'hBB);
        chk("op85_end_cnt",  end_cnt, 5);
        chk("op85_pc_cnt",   pc_cnt, 11);

        // Reset in S3 of the second machine cycle of a 4-cycle instruction.
        wait_ph(14, 8);
        chk("op90_state", int'(bus.state), 3);
        rst = 1'b1;
        bus.hold = 1'b1;
        step();
        #1;
        chk("mid_rst_state",    int'(bus.state), 0);
        chk("mid_rst_cycles",   int'(bus.cycles), 0);
        chk("mid_rst_IR",       int'(bus.IR), 0);
        chk("mid_rst_direct",   int'(bus.direct), 0);
        chk("mid_rst_operand2", int'(bus.operand2), 0);
        chk("mid_rst_pc_inc",   int'(bus.pc_inc), 0);
        chk("mid_rst_start",    int'(bus.ins_start), 0);
        chk("mid_rst_end",      int'(bus.ins_end), 0);
        rst = 1'b0;
        bus.hold = 1'b0;
        step();
        chk("post_rst_state",   int'(bus.state), 1);
        chk("post_rst_end_cnt", end_cnt, 5);

        // Length code 00 behaves as one byte; cycle code 11 as four cycles.
        wait_ph(15, 1);
        chk("opA5_IR",     int'(bus.IR), 8'hA5);
        chk("opA5_cycles", int'(bus.cycles), 3);
        wait_ph(15, 0);
        chk("opA5_end_cnt", end_cnt, 6);
        chk("opA5_len",     t_len, 22);

        repeat (10) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port code_data  input  8  byte returned by CODE memory.
REQ-004 SHALL have port code_rdy  input  1  code_data valid this cycle.
REQ-005 SHALL have port len_lut  input  2  byte length of opcode on code_data (01=1, 10=2, 11=3, 00 treated as 1), combinational from decoder.
REQ-006 SHALL have port cyc_lut  input  2  machine cycles of opcode on code_data (00=1, 01=2, 10=4, 11=4).
REQ-007 SHALL have port hold  input  1  freeze sequencer (external stall).
REQ-008 SHALL have port code_req  output  1  request next CODE byte.
REQ-009 SHALL have port pc_inc  output  1  one-clock pulse per accepted CODE byte.
REQ-010 SHALL have port state  output  3  phase S1..S6 encoded 1..6; 0 = idle.
REQ-011 SHALL have port cycles  output  2  machine cycles remaining after the current one.
REQ-012 SHALL have port IR  output  8  current opcode.
REQ-013 SHALL have port direct  output  8  second instruction byte.
REQ-014 SHALL have port operand2  output  8  third instruction byte.
REQ-015 SHALL have port ins_start  output  1  one-clock pulse when opcode is accepted.
REQ-016 SHALL have port ins_end  output  1  one-clock pulse in final S6 of an instruction.

Function
REQ-017 Phase SHALL advance S1->S2->...->S6->S1 one step per clk, except when stalled.
REQ-018 Stall SHALL occur when hold=1, or in a fetch slot with code_rdy=0; stalled cycles SHALL change no register and emit no pulse.
REQ-019 Fetch slots: opcode in S1 of machine cycle 1; byte 2 in S4 of cycle 1 (len>=2); byte 3 in S1 of cycle 2 (len=3).
REQ-020 code_req SHALL equal (fetch slot active) AND NOT hold; a byte is accepted when code_req=1 and code_rdy=1.
REQ-021 pc_inc SHALL pulse, registered, in the cycle after each accepted byte, exactly once per byte.
REQ-022 On opcode accept: IR<=code_data, len latched, cycles<=N-1 where N from cyc_lut; ins_start pulses next cycle.
REQ-023 If len=3 and cyc_lut=00, N SHALL be forced to 2 (cycles<=1).
REQ-024 Bytes not fetched (len<3 / len<2) SHALL leave operand2 / direct unchanged.
REQ-025 On each S6->S1 transition with cycles>0, cycles SHALL decrement by 1.
REQ-026 In S6 with cycles=0 (not stalled), ins_end SHALL pulse; the next S1 is the next instruction's opcode slot.
REQ-027 ins_end and ins_start of consecutive instructions SHALL never be asserted in the same cycle (ins_start follows S1 accept).
REQ-028 Latency: opcode visible on IR the clock after acceptance, while state=2.
REQ-029 hold asserted during a fetch slot SHALL drop code_req that cycle; a byte presented with code_rdy=1 while hold=1 SHALL NOT be accepted.

Reset
REQ-030 While rst=1: state=0, cycles=0, IR=0, direct=0, operand2=0, code_req=0, pc_inc=0, ins_start=0, ins_end=0; rst SHALL dominate hold.
REQ-031 First clk with rst=0 SHALL move state 0->1 (S1 opcode slot); rst mid-instruction SHALL abandon it with no ins_end.

Verification
REQ-032 Reset then code_rdy=1 constant, byte 0x04 len=01 cyc=00 -> IR=0x04, one pc_inc, ins_end at 6th phase after S1, next opcode fetched in following S1.
REQ-033 Opcode 0xE5 len=10 cyc=00, byte2 0x30 -> direct=0x30 after S4 accept, two pc_inc pulses, cycles=0 throughout.
REQ-034 Opcode 0x02 len=11 cyc=00, bytes 0x12,0x34 -> cycles forced 1, direct=0x12 (C1 S4), operand2=0x34 (C2 S1), ins_end after 12 phases, three pc_inc.
REQ-035 Opcode with cyc=10 -> cycles sequence 3,2,1,0 across four machine cycles, single ins_end.
REQ-036 code_rdy=0 for 3 clocks in S4 slot, then hold=1 for 2 clocks -> state frozen at 4, code_req low during hold, no extra pc_inc, resumes unchanged.
REQ-037 rst pulsed during S3 of cycle 2 of a 4-cycle instruction -> all outputs at reset values next clock, no ins_end, state=1 one clock after rst release.
